// File: rtl/minv_seq_ctrl.sv
// minv_seq_ctrl: issues one micro-op per cycle for the binary extended-Euclid inversion datapath,
// detecting termination or failure and writing the minv result-select flag.
module minv_seq_ctrl #(
    parameter int W       = 32,
    parameter int MAX_OPS = 4 * W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       u_is_one,
    input  logic       v_is_one,
    input  logic       u_is_zero,
    input  logic       v_is_zero,
    input  logic       u_even,
    input  logic       v_even,
    input  logic       u_ge_v,
    output logic [2:0] op,
    output logic       op_valid,
    output logic       minv_flag_we,
    output logic       minv_flag_in,
    output logic       busy,
    output logic       done,
    output logic       err
);
    localparam int CNT_W = $clog2(MAX_OPS + 1);
    localparam logic [1:0] S_IDLE = 2'd0, S_LOAD = 2'd1, S_ITER = 2'd2, S_FIN = 2'd3;
    localparam logic [2:0] OP_NOP = 3'd0, OP_LOAD = 3'd1, OP_HALVE_U = 3'd2,
                           OP_HALVE_V = 3'd3, OP_SUB_U = 3'd4, OP_SUB_V = 3'd5;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             fail;
    logic             at_max, ok, term;
    logic [2:0]       next_op;

    always_comb begin
        at_max  = cnt == CNT_W'(MAX_OPS);
        ok      = u_is_one | v_is_one;
        term    = ok | u_is_zero | v_is_zero | at_max;
        next_op = u_even ? OP_HALVE_U : v_even ? OP_HALVE_V : u_ge_v ? OP_SUB_U : OP_SUB_V;
    end

    // Status already reflects the op on the bus this cycle, so the decision for
    // the next cycle is taken from it in LOAD as well as ITER.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            fail         <= 1'b0;
            op           <= OP_NOP;
            op_valid     <= 1'b0;
            minv_flag_we <= 1'b0;
            minv_flag_in <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            op           <= OP_NOP;
            op_valid     <= 1'b0;
            minv_flag_we <= 1'b0;
            minv_flag_in <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    state    <= S_LOAD;
                    cnt      <= '0;
                    busy     <= 1'b1;
                    op       <= OP_LOAD;
                    op_valid <= 1'b1;
                end
                S_LOAD, S_ITER: if (abort) begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end else if (term) begin
                    state        <= S_FIN;
                    fail         <= ~ok;
                    minv_flag_we <= ok;
                    minv_flag_in <= ok & ~u_is_one;
                end else begin
                    state    <= S_ITER;
                    op       <= next_op;
                    op_valid <= 1'b1;
                    cnt      <= at_max ? cnt : cnt + 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    err   <= fail;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_minv_seq_ctrl.sv
// tb_minv_seq_ctrl: directed and random checks of the inversion sequencer driving a behavioural datapath.
module tb_minv_seq_ctrl;
    localparam logic [2:0] LOAD = 3'd1, HALVE_U = 3'd2, HALVE_V = 3'd3, SUB_U = 3'd4, SUB_V = 3'd5;

    logic clk = 0, rst = 0, start1 = 0, start2 = 0, abort = 0, abort2 = 0;
    logic u_is_one, v_is_one, u_is_zero, v_is_zero, u_even, v_even, u_ge_v;
    logic [2:0] op1, op2;
    logic valid1, we1, in1, busy1, done1, err1;
    logic valid2, we2, in2, busy2, done2, err2;

    int n_checks = 0, n_fail = 0;
    int cyc = 0, t0 = 0;
    int dp_a, dp_p, u, v, x1, x2;
    int nops, ops_sig, nloads, nwe, ndone, load_cyc, we_cyc, done_cyc;
    bit sel = 0, flag, err_seen;

    minv_seq_ctrl dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort),
        .u_is_one(u_is_one), .v_is_one(v_is_one), .u_is_zero(u_is_zero), .v_is_zero(v_is_zero),
        .u_even(u_even), .v_even(v_even), .u_ge_v(u_ge_v),
        .op(op1), .op_valid(valid1), .minv_flag_we(we1), .minv_flag_in(in1),
        .busy(busy1), .done(done1), .err(err1)
    );

    minv_seq_ctrl #(.MAX_OPS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2),
        .u_is_one(u_is_one), .v_is_one(v_is_one), .u_is_zero(u_is_zero), .v_is_zero(v_is_zero),
        .u_even(u_even), .v_even(v_even), .u_ge_v(u_ge_v),
        .op(op2), .op_valid(valid2), .minv_flag_we(we2), .minv_flag_in(in2),
        .busy(busy2), .done(done2), .err(err2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign u_is_one  = u == 1;
    assign v_is_one  = v == 1;
    assign u_is_zero = u == 0;
    assign v_is_zero = v == 0;
    assign u_even    = u % 2 == 0;
    assign v_even    = v % 2 == 0;
    assign u_ge_v    = u >= v;

    // Behavioural datapath: applies the op on the bus mid-cycle, before the controller samples status.
    always @(negedge clk) begin
        logic [2:0] o;
        o = sel ? op2 : op1;
        if (sel ? valid2 : valid1) begin
            if (o == LOAD) begin
                u = dp_a; v = dp_p; x1 = 1; x2 = 0; nloads++; load_cyc = cyc;
            end else begin
                nops++; ops_sig = ops_sig * 8 + int'(o);
                if (o == HALVE_U) begin u = u / 2; x1 = (x1 % 2) ? (x1 + dp_p) / 2 : x1 / 2; end
                if (o == HALVE_V) begin v = v / 2; x2 = (x2 % 2) ? (x2 + dp_p) / 2 : x2 / 2; end
                if (o == SUB_U) begin u = u - v; x1 = (x1 - x2 + dp_p) % dp_p; end
                if (o == SUB_V) begin v = v - u; x2 = (x2 - x1 + dp_p) % dp_p; end
            end
        end
        if (sel ? we2 : we1) begin nwe++; we_cyc = cyc; flag = sel ? in2 : in1; end
        if (sel ? done2 : done1) begin ndone++; done_cyc = cyc; err_seen = sel ? err2 : err1; end
    end

    task automatic clear_stats();
        nops = 0; ops_sig = 0; nloads = 0; nwe = 0; ndone = 0;
        load_cyc = -1; we_cyc = -1; done_cyc = -1; flag = 0; err_seen = 0;
    endtask

    task automatic pulse_start(input int a, input int p, input bit s);
        @(negedge clk);
        sel = s; dp_a = a; dp_p = p; clear_stats();
        if (s) start2 = 1; else start1 = 1;
        t0 = cyc;
        @(negedge clk);
        start1 = 0; start2 = 0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (ndone == 0 && n < 400) begin @(negedge clk); n++; end
        n_checks++;
        if (ndone == 0) begin n_fail++; $display("FAIL done_timeout: no done within %0d cycles", n); end
    endtask

    task automatic run(input int a, input int p, input bit s);
        pulse_start(a, p, s);
        wait_done();
    endtask

    task automatic test_reset();
        #1 rst = 1;
        #1;
        n_checks++;
        if ({op1, valid1, we1, in1, busy1, done1, err1} !== 9'd0) begin
            n_fail++; $display("FAIL reset_dut1: got %b want 0", {op1, valid1, we1, in1, busy1, done1, err1});
        end
        n_checks++;
        if ({op2, valid2, we2, in2, busy2, done2, err2} !== 9'd0) begin
            n_fail++; $display("FAIL reset_dut2: got %b want 0", {op2, valid2, we2, in2, busy2, done2, err2});
        end
        @(negedge clk) rst = 0;
    endtask

    task automatic test_basic();
        pulse_start(3, 7, 0);
        n_checks++;
        if ({busy1, valid1, op1} !== {2'b11, LOAD}) begin
            n_fail++; $display("FAIL basic_load: busy/valid/op %b want 11001", {busy1, valid1, op1});
        end
        wait_done();
        n_checks++; if (ops_sig !== 'o533 || nops !== 3) begin n_fail++; $display("FAIL basic_ops: sig %0o n %0d want 533 n 3", ops_sig, nops); end
        n_checks++; if (load_cyc - t0 !== 1) begin n_fail++; $display("FAIL basic_load_cyc: %0d want 1", load_cyc - t0); end
        n_checks++; if (we_cyc - t0 !== 5 || nwe !== 1) begin n_fail++; $display("FAIL basic_we: cyc %0d n %0d want 5 1", we_cyc - t0, nwe); end
        n_checks++; if (flag !== 1) begin n_fail++; $display("FAIL basic_flag: %0d want 1", flag); end
        n_checks++; if (done_cyc - t0 !== 6 || err_seen !== 0) begin n_fail++; $display("FAIL basic_done: cyc %0d err %0d want 6 0", done_cyc - t0, err_seen); end
        n_checks++; if (x2 !== 5) begin n_fail++; $display("FAIL basic_regx2: %0d want 5", x2); end
        n_checks++; if (busy1 !== 0) begin n_fail++; $display("FAIL basic_busy_drop: %0d want 0", busy1); end
    endtask

    task automatic test_trivial();
        run(1, 7, 0);
        n_checks++; if (nops !== 0) begin n_fail++; $display("FAIL one_ops: %0d want 0", nops); end
        n_checks++; if (we_cyc - t0 !== 2 || flag !== 0) begin n_fail++; $display("FAIL one_we: cyc %0d flag %0d want 2 0", we_cyc - t0, flag); end
        n_checks++; if (done_cyc - t0 !== 3 || err_seen !== 0) begin n_fail++; $display("FAIL one_done: cyc %0d err %0d want 3 0", done_cyc - t0, err_seen); end
    endtask

    task automatic test_noninvertible();
        run(3, 9, 0);
        n_checks++; if (ops_sig !== 'o534) begin n_fail++; $display("FAIL ninv_ops: %0o want 534", ops_sig); end
        n_checks++; if (err_seen !== 1 || nwe !== 0 || done_cyc - t0 !== 6) begin
            n_fail++; $display("FAIL ninv_done: err %0d we %0d cyc %0d want 1 0 6", err_seen, nwe, done_cyc - t0);
        end
        run(0, 7, 0);
        n_checks++; if (err_seen !== 1 || nwe !== 0 || nops !== 0 || done_cyc - t0 !== 3) begin
            n_fail++; $display("FAIL zero_done: err %0d we %0d ops %0d cyc %0d want 1 0 0 3", err_seen, nwe, nops, done_cyc - t0);
        end
    endtask

    task automatic test_budget();
        run(3, 7, 1);
        n_checks++; if (nops !== 2 || err_seen !== 1 || nwe !== 0 || done_cyc - t0 !== 5) begin
            n_fail++; $display("FAIL budget: ops %0d err %0d we %0d cyc %0d want 2 1 0 5", nops, err_seen, nwe, done_cyc - t0);
        end
        n_checks++; if (busy1 !== 0) begin n_fail++; $display("FAIL budget_other_idle: busy %0d want 0", busy1); end
    endtask

    task automatic test_abort();
        pulse_start(3, 7, 0);
        repeat (2) @(negedge clk);
        abort = 1;
        @(negedge clk);
        abort = 0;
        n_checks++; if ({busy1, valid1, op1, we1, done1} !== 7'd0) begin
            n_fail++; $display("FAIL abort_idle: %b want 0", {busy1, valid1, op1, we1, done1});
        end
        repeat (8) @(negedge clk);
        n_checks++; if (ndone !== 0 || nwe !== 0 || nops !== 2) begin
            n_fail++; $display("FAIL abort_quiet: done %0d we %0d ops %0d want 0 0 2", ndone, nwe, nops);
        end
        run(3, 7, 0);
        n_checks++; if (err_seen !== 0 || flag !== 1 || x2 !== 5 || done_cyc - t0 !== 6) begin
            n_fail++; $display("FAIL abort_rerun: err %0d flag %0d x2 %0d cyc %0d want 0 1 5 6", err_seen, flag, x2, done_cyc - t0);
        end
    endtask

    task automatic test_start_spam();
        @(negedge clk);
        sel = 0; dp_a = 3; dp_p = 7; clear_stats();
        start1 = 1; t0 = cyc;
        repeat (5) @(negedge clk);
        start1 = 0;
        wait_done();
        repeat (4) @(negedge clk);
        n_checks++; if (nloads !== 1 || ops_sig !== 'o533 || done_cyc - t0 !== 6 || flag !== 1) begin
            n_fail++; $display("FAIL start_spam: loads %0d ops %0o cyc %0d flag %0d want 1 533 6 1", nloads, ops_sig, done_cyc - t0, flag);
        end
    endtask

    task automatic test_async_reset();
        pulse_start(3, 7, 0);
        repeat (2) @(negedge clk);
        n_checks++; if (busy1 !== 1) begin n_fail++; $display("FAIL areset_pre_busy: %0d want 1", busy1); end
        #2 rst = 1;
        #1;
        n_checks++; if ({op1, valid1, we1, in1, busy1, done1, err1} !== 9'd0) begin
            n_fail++; $display("FAIL areset_outputs: %b want 0", {op1, valid1, we1, in1, busy1, done1, err1});
        end
        @(negedge clk) rst = 0;
        run(1, 7, 0);
        n_checks++; if (done_cyc - t0 !== 3 || err_seen !== 0 || flag !== 0) begin
            n_fail++; $display("FAIL areset_rerun: cyc %0d err %0d flag %0d want 3 0 0", done_cyc - t0, err_seen, flag);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            int p, a, inv, got;
            p = 2 * $urandom_range(1, 499) + 1;
            a = $urandom_range(1, p - 1);
            inv = 0;
            for (int k = 1; k < p; k++) if ((a * k) % p == 1) inv = k;
            run(a, p, 0);
            got = flag ? x2 : x1;
            n_checks++; if (err_seen !== (inv == 0)) begin
                n_fail++; $display("FAIL rand_err a=%0d p=%0d: err %0d want %0d", a, p, err_seen, inv == 0);
            end
            if (inv != 0) begin
                n_checks++; if (got !== inv || nwe !== 1) begin
                    n_fail++; $display("FAIL rand_inv a=%0d p=%0d: got %0d we %0d want %0d 1", a, p, got, nwe, inv);
                end
            end
        end
    endtask

    initial begin
        dp_a = 0; dp_p = 1; u = 2; v = 2; x1 = 0; x2 = 0;
        clear_stats();
        test_reset();
        test_basic();
        test_trivial();
        test_noninvertible();
        test_budget();
        test_abort();
        test_start_spam();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
